// File: rtl/out_module.sv
// Output port of the switch fabric: store-and-forward packet buffer with CRC16 re-check.
// Macro OUT_CRC_DROP_EN: when defined, CRC-mismatched packets are rewound instead of forwarded.
module out_module #(
  parameter int DATA_WIDTH     = 32,
  parameter int LENGTH_WIDTH   = 7,
  parameter int PRIORITY_WIDTH = 2,
  parameter int BUF_DEPTH      = 256,
  parameter int DESC_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vld,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic                      full_out,
  input  logic                      rd_ready,
  output logic                      rd_vld,
  output logic                      rd_sop,
  output logic                      rd_eop,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [PRIORITY_WIDTH-1:0] rd_prio,
  output logic                      crc_err
);
  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int DAW   = $clog2(DESC_DEPTH);
  localparam int LW    = LENGTH_WIDTH;
  localparam int PRW   = PRIORITY_WIDTH;
`ifdef OUT_CRC_DROP_EN
  localparam bit CRC_DROP = 1'b1;
`else
  localparam bit CRC_DROP = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_CHECK} w_state_t;
  typedef enum logic {R_IDLE, R_SEND} r_state_t;

  // CRC-16/CCITT (poly 0x1021), one full word per step, MSB first
  function automatic logic [15:0] crc16_32bit(input logic [15:0] c_in, input logic [DATA_WIDTH-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  logic [LW-1:0]  hdr_inv, hdr_len;
  logic [15:0]    hdr_crc;
  logic [PRW-1:0] hdr_prio;
  logic           is_hdr, hdr_accept;

  assign hdr_inv    = data[DATA_WIDTH-1 -: LW];
  assign hdr_len    = data[DATA_WIDTH-LW-1 -: LW];
  assign hdr_crc    = data[PRW +: 16];
  assign hdr_prio   = data[PRW-1:0];
  assign is_hdr     = (hdr_inv == ~hdr_len) && (hdr_len != '0);

  w_state_t             w_state_q, w_state_d;
  r_state_t             r_state_q, r_state_d;
  logic [LW-1:0]        len_q, len_d, cnt_q, cnt_d, rem_q, rem_d;
  logic [15:0]          crc_ref_q, crc_ref_d, crc_acc_q, crc_acc_d;
  logic [PRW-1:0]       prio_q, prio_d, rd_prio_q, rd_prio_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d, used_d;
  logic [DAW:0]         dq_wr_q, dq_wr_d, dq_rd_q, dq_rd_d, desc_cnt_q, desc_cnt_d;
  logic                 crc_err_q, crc_err_d, full_q, full_d;
  logic                 rd_vld_q, rd_vld_d, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
  logic                 mem_we, push, pop, rd_load, crc_ok;
  logic [AW-1:0]        rd_addr;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [LW-1:0]        desc_len_q  [DESC_DEPTH];
  logic [PRW-1:0]       desc_prio_q [DESC_DEPTH];

  assign hdr_accept = vld && is_hdr && (w_state_q != W_DATA);
  assign desc_cnt_q = dq_wr_q - dq_rd_q;
  assign pop        = (r_state_q == R_IDLE) && (desc_cnt_q != '0);

  always_comb begin
    w_state_d    = w_state_q;
    len_d        = len_q;
    crc_ref_d    = crc_ref_q;
    prio_d       = prio_q;
    cnt_d        = cnt_q;
    crc_acc_d    = crc_acc_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    crc_err_d    = 1'b0;
    crc_ok       = (crc_acc_q == crc_ref_q);
    push         = 1'b0;
    mem_we       = 1'b0;
    unique case (w_state_q)
      W_DATA: begin
        if (vld) begin
          mem_we    = 1'b1;
          wr_ptr_d  = wr_ptr_q + PTR_W'(1);
          cnt_d     = cnt_q + LW'(1);
          crc_acc_d = crc16_32bit(crc_acc_q, data);
          if (cnt_d == len_q) w_state_d = W_CHECK;
        end
      end
      W_CHECK: begin
        crc_err_d = !crc_ok;
        if (crc_ok || !CRC_DROP) begin
          commit_ptr_d = wr_ptr_q;
          push         = 1'b1;
        end else begin
          wr_ptr_d = commit_ptr_q;
        end
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // A header in W_CHECK starts the next packet straight away
    if (hdr_accept) begin
      len_d     = hdr_len;
      crc_ref_d = hdr_crc;
      prio_d    = hdr_prio;
      cnt_d     = '0;
      crc_acc_d = 16'hFFFF;
      w_state_d = W_DATA;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rem_d     = rem_q;
    rd_ptr_d  = rd_ptr_q;
    rd_vld_d  = rd_vld_q;
    rd_sop_d  = rd_sop_q;
    rd_eop_d  = rd_eop_q;
    rd_prio_d = rd_prio_q;
    rd_load   = 1'b0;
    rd_addr   = rd_ptr_q[AW-1:0];
    unique case (r_state_q)
      R_IDLE: begin
        if (pop) begin
          rem_d     = desc_len_q[dq_rd_q[DAW-1:0]];
          rd_prio_d = desc_prio_q[dq_rd_q[DAW-1:0]];
          rd_vld_d  = 1'b1;
          rd_sop_d  = 1'b1;
          rd_eop_d  = (desc_len_q[dq_rd_q[DAW-1:0]] == LW'(1));
          rd_load   = 1'b1;
          r_state_d = R_SEND;
        end
      end
      default: begin
        if (rd_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          rd_sop_d = 1'b0;
          if (rd_eop_q) begin
            rd_vld_d  = 1'b0;
            rd_eop_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rem_d    = rem_q - LW'(1);
            rd_eop_d = (rem_q == LW'(2));
            rd_load  = 1'b1;
            rd_addr  = rd_ptr_d[AW-1:0];
          end
        end
      end
    endcase
  end

  assign dq_wr_d    = push ? dq_wr_q + (DAW+1)'(1) : dq_wr_q;
  assign dq_rd_d    = pop  ? dq_rd_q + (DAW+1)'(1) : dq_rd_q;
  assign desc_cnt_d = dq_wr_d - dq_rd_d;
  assign used_d     = wr_ptr_d - rd_ptr_d;
  // Uncommitted words count as used, so an accepted header always has room for a max-length packet
  assign full_d     = ((BUF_DEPTH - int'(used_d)) < (2 ** LW)) || (int'(desc_cnt_d) >= DESC_DEPTH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      crc_ref_q    <= '0;
      crc_acc_q    <= '0;
      prio_q       <= '0;
      rd_prio_q    <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      dq_wr_q      <= '0;
      dq_rd_q      <= '0;
      crc_err_q    <= 1'b0;
      full_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      crc_ref_q    <= crc_ref_d;
      crc_acc_q    <= crc_acc_d;
      prio_q       <= prio_d;
      rd_prio_q    <= rd_prio_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dq_wr_q      <= dq_wr_d;
      dq_rd_q      <= dq_rd_d;
      crc_err_q    <= crc_err_d;
      full_q       <= full_d;
      rd_vld_q     <= rd_vld_d;
      rd_sop_q     <= rd_sop_d;
      rd_eop_q     <= rd_eop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= data;
    if (push) begin
      desc_len_q[dq_wr_q[DAW-1:0]]  <= len_q;
      desc_prio_q[dq_wr_q[DAW-1:0]] <= prio_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_load) rd_data_q <= mem_q[rd_addr];
  end

  assign full_out = full_q;
  assign rd_vld   = rd_vld_q;
  assign rd_sop   = rd_sop_q;
  assign rd_eop   = rd_eop_q;
  assign rd_data  = rd_data_q;
  assign rd_prio  = rd_prio_q;
  assign crc_err  = crc_err_q;
endmodule

// File: tb/tb_out_module.sv
// Directed bench for out_module: framing, CRC handling, backpressure, fill and reset.
module tb_out_module;
  logic        clk = 1'b0;
  logic        rst_n, vld, rd_ready;
  logic [31:0] data;
  logic        full_out, rd_vld, rd_sop, rd_eop, crc_err;
  logic [31:0] rd_data;
  logic [1:0]  rd_prio;

  out_module dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .data(data), .full_out(full_out),
    .rd_ready(rd_ready), .rd_vld(rd_vld), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .rd_data(rd_data), .rd_prio(rd_prio), .crc_err(crc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  prio;
    int          cyc;
  } rx_t;

  rx_t         rx_q[$];
  logic [31:0] pay_q[$];
  int          cyc_n = 0, crc_err_cnt = 0, stall_cnt = 0, stall_viol = 0;
  int          errors = 0, checks = 0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_out = '0;

  // Sink-side monitor: records every handshake and checks outputs hold while stalled
  always @(negedge clk) begin
    rx_t r;
    cyc_n++;
    if (rd_vld && rd_ready) begin
      r.d = rd_data; r.sop = rd_sop; r.eop = rd_eop; r.prio = rd_prio; r.cyc = cyc_n;
      rx_q.push_back(r);
    end
    if (crc_err) crc_err_cnt++;
    if (prev_stall) begin
      stall_cnt++;
      if ({rd_vld, rd_data, rd_sop, rd_eop, rd_prio} !== prev_out) stall_viol++;
    end
    prev_stall = rd_vld && !rd_ready;
    prev_out   = {rd_vld, rd_data, rd_sop, rd_eop, rd_prio};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-wise CRC-16/CCITT (init 0xFFFF) over pay_q, big-endian bytes
  function automatic logic [15:0] model_crc();
    logic [15:0] c = 16'hFFFF;
    logic [7:0]  b;
    foreach (pay_q[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = pay_q[i][8*k +: 8];
        c = c ^ {b, 8'h00};
        for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  // Header then the first n_send payload words, no idle cycle at the end
  task automatic send_pkt(input logic [1:0] prio, input logic [15:0] crc_xor, input int n_send);
    logic [6:0]  l;
    logic [15:0] c;
    l = 7'(pay_q.size());
    c = model_crc() ^ crc_xor;
    vld = 1'b1; data = {~l, l, c, prio};
    step();
    for (int i = 0; i < n_send; i++) begin
      data = pay_q[i];
      step();
    end
    vld = 1'b0; data = '0;
  endtask

  task automatic wait_rx(input int n, input int bound);
    for (int k = 0; k < bound && rx_q.size() < n; k++) step();
  endtask

  initial begin
    logic [3:0] sv, ev;
    logic [7:0] pv;
    int         bad, base_err;
    bit         seen;

    rst_n = 1'b0; vld = 1'b0; data = '0; rd_ready = 1'b1;
    repeat (3) step();
    chk("reset_outs", {rd_vld, rd_sop, rd_eop, full_out, crc_err, rd_prio, rd_data}, 64'd0);
    rst_n = 1'b1;
    step();

    // Single packet
    pay_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_pkt(2'd2, 16'h0, 4);
    wait_rx(4, 30);
    repeat (5) step();
    chk("single_cnt", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      sv = '0; ev = '0; pv = '0;
      for (int i = 0; i < 4; i++) begin
        sv[3-i] = rx_q[i].sop; ev[3-i] = rx_q[i].eop; pv[7-2*i -: 2] = rx_q[i].prio;
      end
      chk("single_d0", rx_q[0].d, 32'h11111111);
      chk("single_d3", rx_q[3].d, 32'h44444444);
      chk("single_sop", sv, 4'b1000);
      chk("single_eop", ev, 4'b0001);
      chk("single_prio", pv, 8'hAA);
      chk("single_consec", rx_q[3].cyc - rx_q[0].cyc, 3);
    end
    chk("single_crcerr", crc_err_cnt, 0);
    rx_q.delete();

    // Bad CRC, then a good short packet
    send_pkt(2'd2, 16'h0001, 4);
    repeat (15) step();
    chk("bad_crcerr", crc_err_cnt, 1);
`ifdef OUT_CRC_DROP_EN
    chk("bad_dropped", rx_q.size(), 0);
`else
    chk("bad_forwarded", rx_q.size(), 4);
`endif
    rx_q.delete();
    pay_q = '{32'hAAAA0001, 32'hAAAA0002};
    send_pkt(2'd1, 16'h0, 2);
    wait_rx(2, 30);
    repeat (3) step();
    chk("after_bad_cnt", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("after_bad_d0", rx_q[0].d, 32'hAAAA0001);
      chk("after_bad_d1", rx_q[1].d, 32'hAAAA0002);
    end
    chk("after_bad_err", crc_err_cnt, 1);
    rx_q.delete();

    // Back-to-back: second header lands in the first packet's check cycle
    pay_q = '{32'hB0000001, 32'hB0000002, 32'hB0000003};
    send_pkt(2'd1, 16'h0, 3);
    pay_q = '{32'hC0000001};
    send_pkt(2'd3, 16'h0, 1);
    wait_rx(4, 40);
    repeat (3) step();
    chk("b2b_cnt", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      sv = '0; ev = '0; pv = '0;
      for (int i = 0; i < 4; i++) begin
        sv[3-i] = rx_q[i].sop; ev[3-i] = rx_q[i].eop; pv[7-2*i -: 2] = rx_q[i].prio;
      end
      chk("b2b_d2", rx_q[2].d, 32'hB0000003);
      chk("b2b_d3", rx_q[3].d, 32'hC0000001);
      chk("b2b_sop", sv, 4'b1001);
      chk("b2b_eop", ev, 4'b0011);
      chk("b2b_prio", pv, 8'b01010111);
      chk("b2b_gap", 64'(rx_q[3].cyc - rx_q[2].cyc >= 2), 1);
    end
    rx_q.delete();

    // Backpressure 1,0,0,1 during a len=5 packet
    rd_ready = 1'b0;
    pay_q = '{32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004, 32'hD0000005};
    send_pkt(2'd0, 16'h0, 5);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rd_vld) begin seen = 1'b1; break; end
      step();
    end
    chk("bp_vld_seen", seen, 1);
    stall_cnt = 0;
    rd_ready = 1'b1; step();
    rd_ready = 1'b0; step(); step();
    rd_ready = 1'b1;
    wait_rx(5, 20);
    repeat (3) step();
    chk("bp_cnt", rx_q.size(), 5);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i].d !== pay_q[i]) bad++;
    chk("bp_data_bad", bad, 0);
    chk("bp_stalls", stall_cnt, 2);
    chk("bp_stall_hold", stall_viol, 0);
    rx_q.delete();

    // Fill with two max-length packets while the sink is stalled
    rd_ready = 1'b0;
    chk("fill_pre", full_out, 0);
    pay_q.delete();
    for (int i = 0; i < 127; i++) pay_q.push_back(32'hE0000000 + i);
    send_pkt(2'd1, 16'h0, 127);
    repeat (3) step();
    chk("fill_first", full_out, 0);
    pay_q.delete();
    for (int i = 0; i < 127; i++) pay_q.push_back(32'hF0000000 + i);
    send_pkt(2'd2, 16'h0, 127);
    repeat (3) step();
    chk("fill_full", full_out, 1);
    rd_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (!full_out) break;
    end
    chk("fill_release_at", rx_q.size(), 126);
    wait_rx(254, 600);
    repeat (3) step();
    chk("fill_cnt", rx_q.size(), 254);
    bad = 0;
    foreach (rx_q[i]) if (rx_q[i].d !== (i < 127 ? 32'hE0000000 + i : 32'hF0000000 + (i - 127))) bad++;
    chk("fill_data_bad", bad, 0);
    rx_q.delete();

    // Garbage word in idle, then mid-packet reset
    base_err = crc_err_cnt;
    vld = 1'b1; data = 32'h12345678; step();
    vld = 1'b0; data = '0; step();
    pay_q = '{32'h5A5A0001, 32'h5A5A0002};
    send_pkt(2'd3, 16'h0, 2);
    wait_rx(2, 30);
    repeat (3) step();
    chk("garbage_cnt", rx_q.size(), 2);
    if (rx_q.size() == 2) chk("garbage_d1", rx_q[1].d, 32'h5A5A0002);
    rx_q.delete();
    pay_q.delete();
    for (int i = 0; i < 10; i++) pay_q.push_back(32'h00000001 + i);
    send_pkt(2'd1, 16'h0, 5);
    rst_n = 1'b0; step();
    chk("midrst_outs", {rd_vld, rd_sop, rd_eop, full_out, crc_err, rd_prio, rd_data}, 64'd0);
    rst_n = 1'b1;
    for (int i = 5; i < 10; i++) begin
      vld = 1'b1; data = pay_q[i]; step();
    end
    vld = 1'b0; data = '0;
    repeat (30) step();
    chk("midrst_none", rx_q.size(), 0);
    pay_q = '{32'h77777777};
    send_pkt(2'd1, 16'h0, 1);
    wait_rx(1, 30);
    repeat (3) step();
    chk("len1_cnt", rx_q.size(), 1);
    if (rx_q.size() == 1) begin
      chk("len1_data", rx_q[0].d, 32'h77777777);
      chk("len1_sop_eop", {rx_q[0].sop, rx_q[0].eop}, 2'b11);
    end
    chk("final_crcerr", crc_err_cnt - base_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/out_module.md
Name: out_module

Overview:
- Output-port end of the switch fabric: consumes the internal stream emitted by the input modules and reassembles it into external packets.
- Internal stream format: one control word, then payload words.
- Buffers each packet store-and-forward in a sync packet buffer and re-checks CRC16 with crc16_32bit.
- Drives rd_sop/rd_eop/rd_vld/rd_data toward the external sink; asserts full_out back to the crossbar as backpressure.

Parameters:
- DATA_WIDTH, 32, word width; must equal 2*LENGTH_WIDTH+16+PRIORITY_WIDTH.
- LENGTH_WIDTH, 7, payload length field width (payload words, 1..127).
- PRIORITY_WIDTH, 2, priority field width.
- BUF_DEPTH, 256, packet buffer depth in words (power of 2).
- DESC_DEPTH, 4, committed-packet descriptor queue depth (power of 2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous reset, active low.
- vld  in  1  internal word valid from crossbar.
- data  in  DATA_WIDTH  internal word.
- full_out  out  1  backpressure to crossbar; registered.
- rd_ready  in  1  external sink accepts current word.
- rd_vld  out  1  external word valid.
- rd_sop  out  1  first payload word of packet.
- rd_eop  out  1  last payload word of packet.
- rd_data  out  DATA_WIDTH  payload word.
- rd_prio  out  PRIORITY_WIDTH  priority of packet in flight; stable sop..eop.
- crc_err  out  1  one-cycle pulse per packet with CRC mismatch.

Behaviour:
- Reset (rst_n low at posedge): all outputs 0; both FSMs idle; pointers, counters and descriptor queue cleared; any partial or committed packet is discarded.
- Control word layout: [31:25] = ~len, [24:18] = len, [17:2] = crc, [1:0] = prio.
  - A word is a header iff data[31:25] == ~data[24:18] and len != 0.
- Write FSM W_IDLE / W_DATA / W_CHECK:
  - W_IDLE: a vld header latches len, crc, prio; CRC engine is reset (crc_rst_n low this cycle); go to W_DATA. A vld non-header word is dropped and the FSM stays in W_IDLE.
  - W_DATA: each vld word is written at wr_ptr, fed to CRC (crc_en), and cnt increments. Headers are not recognised here; words are treated as payload. When cnt reaches len, go to W_CHECK.
  - W_CHECK (1 cycle): compare crc_out with latched crc.
    - Match: commit_ptr <= wr_ptr; push {len, prio} into descriptor queue.
    - Mismatch: crc_err = 1 for one cycle; wr_ptr <= commit_ptr (rewind).
    - A vld header in this cycle is accepted exactly as in W_IDLE (back-to-back packets). A vld non-header is dropped. Next state is W_DATA or W_IDLE accordingly.
- full_out (registered):
  - Asserts when free buffer words (BUF_DEPTH − (wr_ptr − rd_ptr)) < 128, or descriptor queue holds ≥ DESC_DEPTH−1 entries.
  - Freed space from reads or rewinds deasserts it one cycle later.
  - Crossbar contract: a header is sent only while full_out = 0. Once a header is accepted, the whole packet is guaranteed to fit.
- Read FSM R_IDLE / R_SEND:
  - R_IDLE: descriptor queue non-empty → pop; load rem = len and rd_prio; go to R_SEND. rd_vld rises the following cycle, at least 2 cycles after commit.
  - R_SEND: rd_vld = 1, rd_data = buf[rd_ptr]. rd_sop = 1 on the first word; rd_eop = 1 when rem == 1.
  - Outputs hold stable while rd_vld && !rd_ready; advance only on rd_vld && rd_ready.
  - After the eop handshake, rd_vld = 0 for ≥ 1 cycle, then return to R_IDLE. No overlap between packets.
  - len = 1: rd_sop and rd_eop are both high on the same word.
- Pointer arithmetic: log2(BUF_DEPTH)+1 bits each, wrapping mod 2·BUF_DEPTH; the MSB distinguishes full from empty.
- Simultaneous events:
  - Commit and read-side pop in the same cycle are both honoured.
  - A rewind never crosses rd_ptr, because the read side only consumes committed data.

Optional Feature:
- Macro OUT_CRC_DROP_EN.
- Defined: CRC-mismatched packets are discarded by rewind, as above.
- Undefined: mismatched packets are committed and forwarded like good ones; crc_err still pulses in W_CHECK.

Test Plan:
- Single packet: header len = 4, prio = 2, correct CRC, payload 0x11111111..0x44444444, rd_ready = 1 → rd_vld high for 4 consecutive cycles; sop on 0x11111111, eop on 0x44444444; rd_prio = 2; crc_err stays 0.
- Bad CRC: same packet with header crc field XOR 0x0001 → crc_err pulses once, no rd_vld. Follow with a good len = 2 packet → only the 2 words appear, and they come from the rewound buffer location.
- Back-to-back: second header arriving in the W_CHECK cycle of the first packet (len 3, then len 1) → both emitted in order; the len = 1 word has sop = eop = 1.
- Backpressure: rd_ready toggled 1,0,0,1 during a len = 5 packet → each word held stable while stalled; exactly 5 handshakes; no word dropped or duplicated.
- Fill: send 2 packets of len 127 with rd_ready = 0 → full_out = 1 after the second commit. Raise rd_ready → full_out drops after free space ≥ 128.
- Garbage and reset: a non-header word 0x12345678 in W_IDLE is ignored. rst_n low in the middle of a len = 10 packet → all outputs 0 next cycle; no partial packet is ever emitted.
